// File: rtl/instr_fetch_resp.sv
// ---------------------------------------------------------------------------
// instr_fetch_resp
//
// Responder end of the instruction-fetch interface. It accepts an instruction
// address from the PC, reads the internal instruction store after a fixed
// LATENCY, and returns the word with a one-cycle valid strobe. A preload port
// lets boot logic or a bench fill the store at any time.
//
// Parameters
//   ADDR_W     request address width
//   DATA_W     instruction word width
//   DEPTH_LOG2 log2 of store depth in words
//   LATENCY    cycles from request acceptance to instr_vld (1..15)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset (store contents are kept)
//   req_vld    fetch request present on iaddr
//   iaddr      requested instruction address
//   hlt        halt, blocks acceptance of new requests only
//   rdy        responder can accept a request this cycle (combinational)
//   instr_vld  one-cycle strobe, instr/instr_addr valid
//   instr      fetched instruction word (held until the next response)
//   instr_addr full address the word was fetched from
//   ld_en      preload write enable
//   ld_addr    preload address (low DEPTH_LOG2 bits used)
//   ld_data    preload data
// ---------------------------------------------------------------------------
module instr_fetch_resp #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              hlt,
    output logic              rdy,
    output logic              instr_vld,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // WAIT spends LATENCY-1 cycles: the counter is loaded with LATENCY-2 and
    // RESP is entered on the edge where it reads zero.
    localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam bit         SINGLE   = (LATENCY == 1);

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   instr_addr_reg;
    logic [DATA_W-1:0]   instr_reg;
    logic                instr_vld_reg;

    logic [DATA_W-1:0]   store [0:(1<<DEPTH_LOG2)-1];

    logic                accept;
    logic                enter_resp;
    logic [ADDR_W-1:0]   rd_addr;
    logic                unused_ld_bits;

    assign rdy        = ((state_reg == IDLE) || (state_reg == RESP)) && !hlt;
    assign accept     = rdy && req_vld;

    // With LATENCY==1 the store is read on the accept edge itself, so the
    // address must come straight from iaddr rather than the capture register.
    assign enter_resp = (SINGLE && accept) ||
                        ((state_reg == WAIT) && (cnt_reg == 4'd0));
    assign rd_addr    = SINGLE ? iaddr : addr_reg;

    // Upper preload address bits are ignored (addresses wrap).
    assign unused_ld_bits = ^ld_addr;

    assign instr_vld  = instr_vld_reg;
    assign instr      = instr_reg;
    assign instr_addr = instr_addr_reg;

    // Request sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            addr_reg       <= '0;
            instr_addr_reg <= '0;
            instr_vld_reg  <= 1'b0;
        end else begin
            instr_vld_reg <= enter_resp;
            if (enter_resp) begin
                instr_addr_reg <= rd_addr;
            end
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_reg <= iaddr;
                        if (SINGLE) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_INIT;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Instruction store: write port for preload, registered read port that
    // loads the output word on RESP entry. Nonblocking semantics give
    // read-before-write when both hit the same index on one edge.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            store[ld_addr[DEPTH_LOG2-1:0]] <= ld_data;
        end
        if (rst) begin
            instr_reg <= '0;
        end else if (enter_resp) begin
            instr_reg <= store[rd_addr[DEPTH_LOG2-1:0]];
        end
    end

endmodule

// File: doc/instr_fetch_resp.md
# instr_fetch_resp

Responder end of the instruction-fetch interface. Accepts instruction-address requests from the program counter, reads an internal instruction store with a fixed, parameterized latency, and returns the instruction word with a one-cycle valid strobe. Sits between the PC and the decode stage in the IF block. Provides a preload port so the bench and boot logic can fill the store.

## Interface
- ADDR_W, 16: request address width.
- DATA_W, 16: instruction word width.
- DEPTH_LOG2, 10: log2 of store depth in words (1024 words).
- LATENCY, 2: cycles from request acceptance to `instr_vld`. Legal range is 1..15.

- clk  in  1  single clock; all state updates on the posedge.
- rst  in  1  reset, synchronous, active-high.
- req_vld  in  1  PC presents a fetch request on `iaddr`.
- iaddr  in  ADDR_W  requested instruction address.
- hlt  in  1  halt; blocks acceptance of new requests.
- rdy  out  1  responder can accept a request this cycle.
- instr_vld  out  1  one-cycle strobe; `instr` and `instr_addr` are valid.
- instr  out  DATA_W  fetched instruction word.
- instr_addr  out  ADDR_W  address that `instr` was fetched from.
- ld_en  in  1  preload write enable.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.

## Operation
- **States:** IDLE, WAIT, RESP. Reset state is IDLE.
- **`rdy`:** `rdy = (state==IDLE || state==RESP) && !hlt`. It is combinational from the state register and `hlt`.
- **Accept:** a request is accepted on an edge where `rdy && req_vld`. On acceptance:
  - `iaddr` is captured into an internal address register.
  - If LATENCY==1, next state is RESP.
  - Otherwise, next state is WAIT and `cnt` is loaded with LATENCY-2.
- **WAIT:**
  - If `cnt==0`, next state is RESP.
  - Otherwise, `cnt` decrements and the state stays WAIT.
  - `req_vld` is ignored in WAIT.
- **Entering RESP:** on the edge into RESP, `instr <= store[addr_q[DEPTH_LOG2-1:0]]` and `instr_addr <= addr_q`.
- **RESP:** `instr_vld` is 1 for exactly this cycle. Next state:
  - If a new request is accepted, WAIT or RESP per the accept rule.
  - Otherwise, IDLE.
- **Indexing:** the store is indexed by the low DEPTH_LOG2 bits of the address. Upper bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2. `instr_addr` echoes the full ADDR_W address.
- **Preload:** on any edge with `ld_en`, `store[ld_addr[DEPTH_LOG2-1:0]] <= ld_data`. This applies in every state, including while `hlt` is high.
  - If a preload write and the RESP-entry read hit the same index on the same edge, the read returns the OLD data (read-before-write).
  - A write on any earlier edge is visible to the read.
- **Halt:** `hlt` only blocks acceptance. An in-flight request (WAIT or RESP) completes normally and still produces `instr_vld`.
- **Output hold:** `instr` and `instr_addr` hold their value until the next RESP entry.
- **Reset:** `rst` has priority over everything and aborts any in-flight request.
  - State goes to IDLE, `cnt` to 0, `instr_vld` to 0, `instr` to 0, `instr_addr` to 0, `addr_q` to 0.
  - No `instr_vld` is produced for an aborted request.
  - Store contents are NOT reset.

## Timing
- Request accepted at the edge ending cycle T → `instr_vld`=1 during cycle T+LATENCY.
- Sustained throughput is one instruction per LATENCY cycles. Back-to-back acceptance in RESP means no bubble beyond LATENCY.
- Output values during and immediately after the `rst` cycle: `rdy`=1 (if `!hlt`), `instr_vld`=0, `instr`=0, `instr_addr`=0.
- `rdy` responds to `hlt` in the same cycle (combinational). All other outputs are registered.
- Preload-to-fetch visibility: a write at edge E is returned by a fetch whose RESP-entry edge is E+1 or later.

## Test plan
- **Basic fetch, LATENCY=2:** preload `store[5]=16'hA1B2`, then pulse `req_vld` with `iaddr=5` at cycle T → `instr_vld`=1 only in T+2, `instr=16'hA1B2`, `instr_addr=5`, `rdy`=0 in T+1.
- **Back-to-back stream:** hold `req_vld`=1 with `iaddr` incrementing 0,1,2,3, only changing on accept (store preloaded `i→16'h1000+i`) → `instr_vld` every 2nd cycle with 1000,1001,1002,1003 in order, no drops or duplicates.
- **Halt:** assert `hlt` the cycle after accepting `iaddr=7` → `rdy`=0 immediately, the in-flight fetch still returns `store[7]`, and no new accept occurs until `hlt`=0.
- **Wrap:** DEPTH_LOG2=10, preload `store[3]=16'h5555`, request `iaddr=16'h0403` → `instr=16'h5555`, `instr_addr=16'h0403`.
- **Read/write collision:** `store[9]=16'h0001`, request 9, and drive `ld_en` with `ld_addr=9`, `ld_data=16'h0002` on the RESP-entry edge → `instr=16'h0001`. A repeat request returns 16'h0002.
- **Reset mid-op:** LATENCY=4, accept a request, assert `rst` in the WAIT cycle → no `instr_vld` ever for that request, `instr`=0, `rdy`=1 the cycle after `rst`, store contents intact.
